axi_imem_slave: RTL and testbench

//  AXI4 read-only slave instruction memory. Sits directly downstream of the fetch-side AXI read master.

---
 rtl/axi_imem_slave.sv | 184 ++++++++++++++++++
 tb/tb_axi_imem_slave.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_imem_slave.sv
// AXI4 read-only instruction memory slave: one outstanding INCR/FIXED burst, fully registered
// R channel, programmable first-beat latency.
module axi_imem_slave #(
  parameter logic [63:0] BASE_ADDR  = 64'h8000_0000,
  parameter int unsigned DEPTH      = 65536,
  parameter int unsigned RD_LATENCY = 1,
  parameter string       INIT_FILE  = ""
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [3:0]  ARID,
  input  logic [63:0] ARADDR,
  input  logic [7:0]  ARLEN,
  input  logic [2:0]  ARSIZE,
  input  logic [1:0]  ARBURST,
  input  logic [2:0]  ARPROT,
  input  logic        ARVALID,
  output logic        ARREADY,
  output logic [3:0]  RID,
  output logic [63:0] RDATA,
  output logic [1:0]  RRESP,
  output logic        RLAST,
  output logic        RVALID,
  input  logic        RREADY
);

  localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [63:0] SPAN      = 64'(DEPTH) << 3;
  localparam logic [3:0]  WAIT_INIT = 4'((RD_LATENCY > 0) ? RD_LATENCY - 1 : 0);

  typedef enum logic [1:0] {StIdle, StWait, StBurst} state_e;

  state_e      state_q, state_d;
  logic        arready_q, arready_d;
  logic        rvalid_q, rvalid_d;
  logic        rlast_q, rlast_d;
  logic [3:0]  rid_q, rid_d;
  logic [63:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;
  logic [3:0]  id_q, id_d;
  logic [63:0] addr_q, addr_d;
  logic [7:0]  len_q, len_d;
  logic [2:0]  size_q, size_d;
  logic [1:0]  burst_q, burst_d;
  logic [7:0]  beat_q, beat_d;
  logic [3:0]  cnt_q, cnt_d;

  logic [63:0] mem [DEPTH];

  logic unused_arprot;
  assign unused_arprot = ^ARPROT;

  logic [63:0] next_addr, beat_addr, beat_off, beat_word, beat_mask, beat_data;
  logic [1:0]  beat_resp;

  // The beat being loaded is beat 0 (addr_q) on first presentation, else the following address.
  always_comb begin
    next_addr = (burst_q == 2'b01) ? addr_q + (64'd1 << size_q) : addr_q;
    beat_addr = rvalid_q ? next_addr : addr_q;
    beat_off  = beat_addr - BASE_ADDR;
    beat_word = mem[beat_off[AW+2:3]];
    case (size_q[1:0])
      2'd0:    beat_mask = 64'h0000_0000_0000_00ff;
      2'd1:    beat_mask = 64'h0000_0000_0000_ffff;
      2'd2:    beat_mask = 64'h0000_0000_ffff_ffff;
      default: beat_mask = 64'hffff_ffff_ffff_ffff;
    endcase
    beat_data = '0;
    beat_resp = 2'b00;
    if (burst_q[1] || size_q[2]) begin
      beat_resp = 2'b10;
    end else if (beat_off >= SPAN) begin
      beat_resp = 2'b11;
    end else begin
      beat_data = (beat_word >> {beat_addr[2:0], 3'b000}) & beat_mask;
    end
  end

  always_comb begin
    state_d   = state_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    rid_d     = rid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    id_d      = id_q;
    addr_d    = addr_q;
    len_d     = len_q;
    size_d    = size_q;
    burst_d   = burst_q;
    beat_d    = beat_q;
    cnt_d     = cnt_q;
    case (state_q)
      StIdle: begin
        arready_d = 1'b1;
        if (ARVALID && arready_q) begin
          id_d      = ARID;
          addr_d    = ARADDR;
          len_d     = ARLEN;
          size_d    = ARSIZE;
          burst_d   = ARBURST;
          beat_d    = '0;
          arready_d = 1'b0;
          if (RD_LATENCY == 0) begin
            state_d = StBurst;
          end else begin
            state_d = StWait;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      StWait: begin
        if (cnt_q == '0) state_d = StBurst;
        else cnt_d = cnt_q - 4'd1;
      end
      StBurst: begin
        if (!rvalid_q) begin
          rvalid_d = 1'b1;
          rlast_d  = (beat_q == len_q);
          rid_d    = id_q;
          rdata_d  = beat_data;
          rresp_d  = beat_resp;
        end else if (RREADY) begin
          if (beat_q == len_q) begin
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
            arready_d = 1'b1;
            state_d   = StIdle;
          end else begin
            beat_d  = beat_q + 8'd1;
            addr_d  = next_addr;
            rlast_d = (8'(beat_q + 8'd1) == len_q);
            rdata_d = beat_data;
            rresp_d = beat_resp;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= StIdle;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rid_q     <= '0;
      rdata_q   <= '0;
      rresp_q   <= '0;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      beat_q    <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rid_q     <= rid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      id_q      <= id_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      size_q    <= size_d;
      burst_q   <= burst_d;
      beat_q    <= beat_d;
      cnt_q     <= cnt_d;
    end
  end

  assign ARREADY = arready_q;
  assign RVALID  = rvalid_q;
  assign RLAST   = rlast_q;
  assign RID     = rid_q;
  assign RDATA   = rdata_q;
  assign RRESP   = rresp_q;

endmodule

// File: tb/tb_axi_imem_slave.sv
// Bench for axi_imem_slave: two instances (latency 1 and 0) checked every cycle against a
// transaction-level model, plus directed literal checks.
module tb_axi_imem_slave;

  localparam logic [63:0] BASE  = 64'h8000_0000;
  localparam int          DEPTH = 256;
  localparam logic [63:0] SPAN  = 64'(DEPTH) * 8;

  logic clk;
  logic [1:0]  rstn, arvalid, rready, arready, rvalid, rlast;
  logic [3:0]  arid    [2];
  logic [63:0] araddr  [2];
  logic [7:0]  arlen   [2];
  logic [2:0]  arsize  [2];
  logic [1:0]  arburst [2];
  logic [3:0]  rid     [2];
  logic [63:0] rdata   [2];
  logic [1:0]  rresp   [2];

  axi_imem_slave #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .RD_LATENCY(1), .INIT_FILE("")) u_dut_l1 (
    .clk(clk), .rstn(rstn[0]), .ARID(arid[0]), .ARADDR(araddr[0]), .ARLEN(arlen[0]),
    .ARSIZE(arsize[0]), .ARBURST(arburst[0]), .ARPROT(3'b010), .ARVALID(arvalid[0]),
    .ARREADY(arready[0]), .RID(rid[0]), .RDATA(rdata[0]), .RRESP(rresp[0]), .RLAST(rlast[0]),
    .RVALID(rvalid[0]), .RREADY(rready[0])
  );

  axi_imem_slave #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .RD_LATENCY(0), .INIT_FILE("")) u_dut_l0 (
    .clk(clk), .rstn(rstn[1]), .ARID(arid[1]), .ARADDR(araddr[1]), .ARLEN(arlen[1]),
    .ARSIZE(arsize[1]), .ARBURST(arburst[1]), .ARPROT(3'b101), .ARVALID(arvalid[1]),
    .ARREADY(arready[1]), .RID(rid[1]), .RDATA(rdata[1]), .RRESP(rresp[1]), .RLAST(rlast[1]),
    .RVALID(rvalid[1]), .RREADY(rready[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 0;
  endfunction

  // ---------------- reference model ----------------
  logic [63:0] img [DEPTH];
  logic [63:0] exp_d [2][256];
  logic [1:0]  exp_r [2][256];
  logic [1:0]  m_arready, m_rvalid, m_rlast, m_busy, m_fresh;
  logic [3:0]  m_rid [2];
  logic [3:0]  m_id [2];
  logic [63:0] m_rdata [2];
  logic [1:0]  m_rresp [2];
  int          m_wait [2];
  int          m_pos [2];
  int          m_n [2];
  bit          started = 1'b0;

  // Expected beat list of a whole burst, straight from the address/data/error rules.
  function automatic void build(input int k, input logic [63:0] a0, input logic [7:0] len,
                                input logic [2:0] sz, input logic [1:0] bu);
    logic [63:0] a, w, d;
    for (int i = 0; i <= int'(len); i++) begin
      a = (bu == 2'b00) ? a0 : a0 + 64'(i) * (64'd1 << sz);
      if (bu[1] || sz > 3'd3) begin
        exp_d[k][i] = '0;
        exp_r[k][i] = 2'b10;
      end else if (a < BASE || a >= BASE + SPAN) begin
        exp_d[k][i] = '0;
        exp_r[k][i] = 2'b11;
      end else begin
        w = img[int'((a - BASE) >> 3)];
        d = w >> (8 * a[2:0]);
        if (sz < 3'd3) d = d & ((64'd1 << (8 * (1 << sz))) - 64'd1);
        exp_d[k][i] = d;
        exp_r[k][i] = 2'b00;
      end
    end
    m_n[k] = int'(len) + 1;
  endfunction

  function automatic void present(input int k);
    m_rvalid[k] = 1'b1;
    m_rdata[k]  = exp_d[k][m_pos[k]];
    m_rresp[k]  = exp_r[k][m_pos[k]];
    m_rid[k]    = m_id[k];
    m_rlast[k]  = (m_pos[k] == m_n[k] - 1);
    m_fresh[k]  = 1'b0;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
        if (!rstn[k]) begin
          m_arready[k] = 1'b0; m_rvalid[k] = 1'b0; m_rlast[k] = 1'b0; m_busy[k] = 1'b0;
          m_fresh[k] = 1'b1; m_rid[k] = '0; m_rdata[k] = '0; m_rresp[k] = '0;
        end else if (m_busy[k]) begin
          if (m_rvalid[k]) begin
            if (rready[k]) begin
              m_pos[k]++;
              if (m_pos[k] == m_n[k]) begin
                m_rvalid[k] = 1'b0; m_rlast[k] = 1'b0; m_arready[k] = 1'b1; m_busy[k] = 1'b0;
              end else begin
                present(k);
              end
            end
          end else begin
            m_wait[k]--;
            if (m_wait[k] == 0) present(k);
          end
        end else if (arvalid[k] && m_arready[k]) begin
          build(k, araddr[k], arlen[k], arsize[k], arburst[k]);
          m_id[k] = arid[k]; m_pos[k] = 0; m_busy[k] = 1'b1; m_arready[k] = 1'b0;
          m_wait[k] = lat_of(k) + 1;
        end else begin
          m_arready[k] = 1'b1;
        end
      end
      started = 1'b1;
    end
  end

  // Per-cycle compare, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        for (int k = 0; k < 2; k++) begin
          chk($sformatf("k%0d ARREADY", k), 64'(arready[k]), 64'(m_arready[k]));
          chk($sformatf("k%0d RVALID", k), 64'(rvalid[k]), 64'(m_rvalid[k]));
          chk($sformatf("k%0d RLAST", k), 64'(rlast[k]), 64'(m_rlast[k]));
          if (m_rvalid[k] || m_fresh[k]) begin
            chk($sformatf("k%0d RID", k), 64'(rid[k]), 64'(m_rid[k]));
            chk($sformatf("k%0d RDATA", k), rdata[k], m_rdata[k]);
            chk($sformatf("k%0d RRESP", k), 64'(rresp[k]), 64'(m_rresp[k]));
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [63:0] seen_d [64];
  logic [1:0]  seen_r [64];
  logic [3:0]  seen_id [64];
  logic        seen_l [64];
  int          seen_n;

  task automatic ar_send(input int k, input logic [3:0] id, input logic [63:0] a,
                         input logic [7:0] len, input logic [2:0] sz, input logic [1:0] bu);
    bit hs, ok;
    arid[k] = id; araddr[k] = a; arlen[k] = len; arsize[k] = sz; arburst[k] = bu;
    arvalid[k] = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 50 && !ok; c++) begin
      hs = arready[k];
      @(negedge clk);
      if (hs) ok = 1'b1;
    end
    arvalid[k] = 1'b0;
    chk($sformatf("k%0d AR handshake", k), 64'(ok), 64'd1);
  endtask

  task automatic xfer(input int k, input logic [3:0] id, input logic [63:0] a,
                      input logic [7:0] len, input logic [2:0] sz, input logic [1:0] bu,
                      input int rmode);
    int lat, cyc;
    seen_n = 0;
    rready[k] = 1'b1;
    ar_send(k, id, a, len, sz, bu);
    lat = 0;
    while (!rvalid[k] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk($sformatf("k%0d first-beat latency", k), 64'(lat), 64'(lat_of(k) + 1));
    cyc = 0;
    while (seen_n <= int'(len) && cyc < 2000) begin
      case (rmode)
        0:       rready[k] = 1'b1;
        1:       rready[k] = (cyc % 2 == 0);
        default: rready[k] = ($urandom_range(0, 3) != 0);
      endcase
      if (rvalid[k] && rready[k]) begin
        if (seen_n < 64) begin
          seen_d[seen_n] = rdata[k]; seen_r[seen_n] = rresp[k];
          seen_id[seen_n] = rid[k]; seen_l[seen_n] = rlast[k];
        end
        seen_n++;
      end
      @(negedge clk);
      cyc++;
    end
    rready[k] = 1'b0;
    chk($sformatf("k%0d beat count", k), 64'(seen_n), 64'(int'(len) + 1));
  endtask

  task automatic run_directed(input int k);
    int n, cyc, idx, nlast;
    bit hs;
    logic [3:0] t6_ids [6];
    t6_ids = '{4'd5, 4'd5, 4'd6, 4'd7, 4'd7, 4'd7};
    // T1 / T2
    xfer(k, 4'h0, 64'h8000_0000, 8'd0, 3'd2, 2'b01, 0);
    chk("T1 RDATA", seen_d[0], 64'h0000_0000_0000_0297);
    chk("T1 RRESP", 64'(seen_r[0]), 64'd0);
    chk("T1 RLAST", 64'(seen_l[0]), 64'd1);
    xfer(k, 4'h9, 64'h8000_0004, 8'd0, 3'd2, 2'b01, 0);
    chk("T2 RDATA", seen_d[0], 64'h0000_0000_0010_0093);
    chk("T2 RID", 64'(seen_id[0]), 64'h9);
    // T3
    xfer(k, 4'h2, 64'h8000_0000, 8'd3, 3'd3, 2'b01, 1);
    chk("T3 beat0", seen_d[0], 64'h0010_0093_0000_0297);
    chk("T3 beat1", seen_d[1], 64'h1111_2222_3333_4444);
    chk("T3 beat2", seen_d[2], 64'h5555_6666_7777_8888);
    chk("T3 beat3", seen_d[3], 64'h9999_aaaa_bbbb_cccc);
    chk("T3 RLAST beat2", 64'(seen_l[2]), 64'd0);
    chk("T3 RLAST beat3", 64'(seen_l[3]), 64'd1);
    // T4
    xfer(k, 4'h4, 64'h8000_0000, 8'd1, 3'd3, 2'b10, 0);
    chk("T4 wrap resp0", 64'(seen_r[0]), 64'h2);
    chk("T4 wrap resp1", 64'(seen_r[1]), 64'h2);
    chk("T4 wrap data1", seen_d[1], 64'h0);
    xfer(k, 4'h5, 64'h8000_07f8, 8'd1, 3'd3, 2'b01, 0);
    chk("T4 edge data0", seen_d[0], 64'hfeed_face_cafe_beef);
    chk("T4 edge resp0", 64'(seen_r[0]), 64'h0);
    chk("T4 edge resp1", 64'(seen_r[1]), 64'h3);
    chk("T4 edge data1", seen_d[1], 64'h0);
    // T5: reset after beat 2 of an 8-beat burst
    rready[k] = 1'b1;
    ar_send(k, 4'h3, 64'h8000_0000, 8'd7, 3'd3, 2'b01);
    n = 0;
    cyc = 0;
    while (n < 3 && cyc < 100) begin
      if (rvalid[k]) n++;
      @(negedge clk);
      cyc++;
    end
    chk("T5 beats before reset", 64'(n), 64'd3);
    rstn[k] = 1'b0;
    @(negedge clk);
    chk("T5 RVALID at reset edge", 64'(rvalid[k]), 64'd0);
    @(negedge clk);
    rstn[k] = 1'b1;
    rready[k] = 1'b0;
    @(negedge clk);
    chk("T5 ARREADY after reset", 64'(arready[k]), 64'd1);
    xfer(k, 4'h6, 64'h8000_0008, 8'd0, 3'd3, 2'b01, 0);
    chk("T5 fresh read data", seen_d[0], 64'h1111_2222_3333_4444);
    // T6: three queued requests with ARVALID held
    rready[k] = 1'b1;
    seen_n = 0; idx = 0; nlast = 0;
    arid[k] = 4'd5; araddr[k] = BASE + 64'h8; arlen[k] = 8'd1; arsize[k] = 3'd3;
    arburst[k] = 2'b01; arvalid[k] = 1'b1;
    for (int c = 0; c < 200 && nlast < 3; c++) begin
      hs = arvalid[k] && arready[k];
      if (rvalid[k]) begin
        if (seen_n < 64) seen_id[seen_n] = rid[k];
        seen_n++;
        if (rlast[k]) nlast++;
      end
      @(negedge clk);
      if (hs) begin
        idx++;
        case (idx)
          1: begin arid[k] = 4'd6; araddr[k] = BASE + 64'h20; arlen[k] = 8'd0; end
          2: begin arid[k] = 4'd7; araddr[k] = BASE + 64'h40; arlen[k] = 8'd2; end
          default: arvalid[k] = 1'b0;
        endcase
      end
    end
    arvalid[k] = 1'b0;
    rready[k] = 1'b0;
    chk("T6 bursts", 64'(nlast), 64'd3);
    chk("T6 beats", 64'(seen_n), 64'd6);
    for (int i = 0; i < 6; i++) chk($sformatf("T6 RID[%0d]", i), 64'(seen_id[i]), 64'(t6_ids[i]));
  endtask

  task automatic run_random(input int k);
    logic [63:0] a;
    logic [7:0]  len;
    logic [2:0]  sz;
    logic [1:0]  bu;
    int          sel;
    for (int t = 0; t < 30; t++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        6:       a = BASE + SPAN - 64'(8 * $urandom_range(1, 3));
        7:       a = BASE - 64'(8 * $urandom_range(1, 3));
        8:       a = 64'hffff_ffff_ffff_fff8;
        9:       a = BASE + 64'($urandom_range(0, 2047));
        default: a = BASE + 64'($urandom_range(0, 255)) * 8 + 64'($urandom_range(0, 7));
      endcase
      len = ($urandom_range(0, 9) == 0) ? 8'd15 : 8'($urandom_range(0, 5));
      sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      sel = $urandom_range(0, 9);
      bu = (sel < 6) ? 2'b01 : (sel < 8) ? 2'b00 : (sel == 8) ? 2'b10 : 2'b11;
      xfer(k, 4'($urandom_range(0, 15)), a, len, sz, bu, 2);
    end
  endtask

  initial begin
    #200000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 2'b00; arvalid = 2'b00; rready = 2'b00;
    for (int k = 0; k < 2; k++) begin
      arid[k] = '0; araddr[k] = '0; arlen[k] = '0; arsize[k] = '0; arburst[k] = '0;
    end
    for (int i = 0; i < DEPTH; i++) img[i] = {$urandom, $urandom};
    img[0]   = 64'h0010_0093_0000_0297;
    img[1]   = 64'h1111_2222_3333_4444;
    img[2]   = 64'h5555_6666_7777_8888;
    img[3]   = 64'h9999_aaaa_bbbb_cccc;
    img[255] = 64'hfeed_face_cafe_beef;
    for (int i = 0; i < DEPTH; i++) begin
      u_dut_l1.mem[i] = img[i];
      u_dut_l0.mem[i] = img[i];
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("k%0d reset ARREADY", k), 64'(arready[k]), 64'd0);
      chk($sformatf("k%0d reset RVALID", k), 64'(rvalid[k]), 64'd0);
      chk($sformatf("k%0d reset RDATA", k), rdata[k], 64'd0);
    end
    rstn = 2'b11;
    @(negedge clk);
    for (int k = 0; k < 2; k++) chk($sformatf("k%0d ARREADY after reset", k),
                                    64'(arready[k]), 64'd1);
    for (int k = 0; k < 2; k++) begin
      run_directed(k);
      run_random(k);
    end
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
